load_tid_buffer: RTL and testbench
==================================

// Module: load_tid_buffer
// PURPOSE
//  Tracks outstanding loads between load unit and dcache request port. Each accepted load gets a buffer tag.
//  The tag travels with the dcache request; the dcache response returns it. Lookup by tag recovers
//  scoreboard trans_id, byte offset and load op. Entries in flight across a pipeline flush are held until the
//  cache responds, and that response is dropped.
// PARAMETERS
//  NR_ENTRIES  2  outstanding-load slots (matches NrLoadBufEntries); >=1
//  TRANS_ID_W  3  scoreboard transaction id width (clog2 of 8 scoreboard entries)
//  OFFSET_W    3  byte offset within XLEN word, for load realignment
//  OP_W        4  encoded load op (size/sign)
//  TAG_W       max(1,$clog2(NR_ENTRIES))  derived, not overridable
// PORTS
//  clk_i            in   1           clock
//  rst_ni           in   1           synchronous active-low reset
//  alloc_valid_i    in   1           load unit requests a slot
//  alloc_ready_o    out  1           slot available; handshake = valid&ready
//  alloc_trans_id_i in   TRANS_ID_W  scoreboard id of load
//  alloc_offset_i   in   OFFSET_W    byte offset
//  alloc_op_i       in   OP_W        load op
//  alloc_tag_o      out  TAG_W       tag granted this cycle (valid on handshake)
//  kill_last_i      in   1           dcache did not accept last cycle's request; free its slot
//  flush_i          in   1           pipeline flush
//  rsp_valid_i      in   1           dcache load response
//  rsp_tag_i        in   TAG_W       tag returned by dcache
//  rsp_hit_o        out  1           response belongs to a live (PENDING) load; forward to writeback
//  rsp_err_o        out  1           response tag addressed a FREE slot (protocol error)
//  rsp_trans_id_o   out  TRANS_ID_W  looked-up fields, combinational from rsp_tag_i
//  rsp_offset_o     out  OFFSET_W
//  rsp_op_o         out  OP_W
//  count_o          out  $clog2(NR_ENTRIES+1)  occupied slots (PENDING+KILLED)
//  empty_o          out  1           count_o==0
// BEHAVIOUR
//  - Per-slot state: FREE, PENDING, KILLED. Payload regs are written only on allocation.
//  - Reset (rst_ni=0 at posedge): all slots FREE, last-grant flag cleared; payload regs not reset.
//    Resulting outputs: alloc_ready_o=1, count_o=0, empty_o=1. rsp_hit_o/rsp_err_o=0 while rsp_valid_i=0.
//    Reset mid-operation discards all slots; later responses for old tags flag rsp_err_o.
//  - Alloc: the granted slot is the lowest-index FREE slot. alloc_tag_o is combinational.
//    The slot becomes PENDING at the next edge. alloc_ready_o does not depend on alloc_valid_i.
//  - Response lookup is combinational, 0-cycle:
//    rsp_hit_o = rsp_valid_i & PENDING; rsp_err_o = rsp_valid_i & FREE.
//    A response to a PENDING or KILLED slot frees that slot at the next edge.
//    A response to a FREE slot changes no state.
//  - kill_last_i: honoured only in the cycle directly after a handshake; it frees the slot granted then.
//    Ignored otherwise. When honoured, the freed slot overrides any flush_i marking in the same cycle.
//  - flush_i: every PENDING slot becomes KILLED. A slot allocated in the flush cycle is written KILLED.
//    KILLED slots are not allocatable until their response arrives.
//  - Same cycle, flush_i and a response to a PENDING slot: rsp_hit_o=1 (pre-flush state); slot freed.
//  - Same cycle, alloc and response: both applied. The freed slot and the new slot differ (see CONFIGURATION).
//  - count_o is registered state. Allocation, response or kill in cycle N is reflected in cycle N+1.
//    The count never wraps: alloc is impossible when full, frees apply only to occupied slots.
// CONFIGURATION
//  LOAD_TID_BUFFER_BYPASS_EN
//   - Defined: a response freeing slot k in cycle N makes alloc_ready_o=1 in cycle N even when full;
//     the grant picks the lowest FREE slot, else k. On same-slot reuse, the new alloc wins (slot -> PENDING/KILLED with new payload).
//   - Undefined: alloc_ready_o = any slot FREE in registered state only; no comb path rsp_* -> alloc_ready_o.
// TESTING
//  1. Reset, idle inputs -> alloc_ready_o=1, count_o=0, empty_o=1, rsp_hit_o=0.
//  2. Alloc id=3 off=2, then id=5 off=4 -> tags 0,1; then count_o=2, alloc_ready_o=0.
//     rsp tag=1 -> rsp_hit_o=1, rsp_trans_id_o=5, rsp_offset_o=4; next cycle count_o=1.
//  3. Two PENDING, pulse flush_i -> count_o stays 2, alloc_ready_o=0.
//     rsp tag=0 -> rsp_hit_o=0, rsp_err_o=0; after rsp tag=1, empty_o=1.
//  4. Alloc (tag 0), kill_last_i=1 next cycle -> count_o=0 one cycle later.
//     kill_last_i with no prior-cycle handshake -> no change.
//  5. Full, alloc_valid_i=1 with rsp tag=0 same cycle:
//     BYPASS_EN -> handshake, alloc_tag_o=0, count_o stays 2; undefined -> alloc_ready_o=0, count_o 1.
//  6. rsp_valid_i on FREE tag 1 -> rsp_err_o=1, rsp_hit_o=0, count_o unchanged.

Source files
------------

// File: rtl/load_tid_buffer.sv
// load_tid_buffer
//   Tracks loads that are outstanding between the load unit and the dcache
//   request port. Every accepted load is given a buffer tag. The tag travels
//   with the dcache request and comes back with the response, and a lookup by
//   tag then recovers the scoreboard trans_id, byte offset and load op. If a
//   pipeline flush happens while entries are in flight, those entries are held
//   (KILLED) until the cache responds, and that response is dropped.
//
// Optional feature macro: LOAD_TID_BUFFER_BYPASS_EN
//   When defined, a response that frees slot k lets a new allocation proceed
//   in the same cycle, even when the buffer is full. In that case the grant
//   falls back to slot k.
//
// Ports
//   clk_i, rst_ni       clock, synchronous active-low reset
//   alloc_valid_i/_ready_o, alloc_trans_id_i/_offset_i/_op_i, alloc_tag_o
//                       slot allocation handshake and the granted tag
//   kill_last_i         the dcache refused last cycle's request; free that slot
//   flush_i             pipeline flush; live slots become KILLED
//   rsp_valid_i, rsp_tag_i
//                       dcache response
//   rsp_hit_o, rsp_err_o, rsp_trans_id_o/_offset_o/_op_o
//                       combinational lookup of the response tag
//   count_o, empty_o    registered occupancy
module load_tid_buffer #(
  parameter  int unsigned NR_ENTRIES = 2,
  parameter  int unsigned TRANS_ID_W = 3,
  parameter  int unsigned OFFSET_W   = 3,
  parameter  int unsigned OP_W       = 4,
  localparam int unsigned TAG_W      = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
  localparam int unsigned CNT_W      = $clog2(NR_ENTRIES + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
  input  logic [OFFSET_W-1:0]   alloc_offset_i,
  input  logic [OP_W-1:0]       alloc_op_i,
  output logic [TAG_W-1:0]      alloc_tag_o,
  input  logic                  kill_last_i,
  input  logic                  flush_i,
  input  logic                  rsp_valid_i,
  input  logic [TAG_W-1:0]      rsp_tag_i,
  output logic                  rsp_hit_o,
  output logic                  rsp_err_o,
  output logic [TRANS_ID_W-1:0] rsp_trans_id_o,
  output logic [OFFSET_W-1:0]   rsp_offset_o,
  output logic [OP_W-1:0]       rsp_op_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  empty_o
);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_PENDING = 2'd1,
    S_KILLED  = 2'd2
  } slot_e;

  slot_e                 state_q [NR_ENTRIES];
  slot_e                 state_d [NR_ENTRIES];
  logic [TRANS_ID_W-1:0] tid_q   [NR_ENTRIES];
  logic [OFFSET_W-1:0]   off_q   [NR_ENTRIES];
  logic [OP_W-1:0]       op_q    [NR_ENTRIES];

  logic                  last_vld_q, last_vld_d;
  logic [TAG_W-1:0]      last_tag_q, last_tag_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  rsp_in_rng;
  slot_e                 rsp_state;
  logic                  rsp_live;
  logic                  free_found;
  logic [TAG_W-1:0]      grant_tag;
  logic                  handshake;
  logic                  kill_en;

  // Response lookup. A tag outside the array reads as a FREE slot.
  assign rsp_in_rng = (32'(rsp_tag_i) < NR_ENTRIES);

  always_comb begin
    rsp_state      = S_FREE;
    rsp_trans_id_o = '0;
    rsp_offset_o   = '0;
    rsp_op_o       = '0;
    if (rsp_in_rng) begin
      rsp_state      = state_q[rsp_tag_i];
      rsp_trans_id_o = tid_q[rsp_tag_i];
      rsp_offset_o   = off_q[rsp_tag_i];
      rsp_op_o       = op_q[rsp_tag_i];
    end
  end

  assign rsp_live  = rsp_valid_i && (rsp_state != S_FREE);
  assign rsp_hit_o = rsp_valid_i && (rsp_state == S_PENDING);
  assign rsp_err_o = rsp_valid_i && (rsp_state == S_FREE);

  // Grant selection: the lowest FREE slot in the registered state.
  always_comb begin
    free_found = 1'b0;
    grant_tag  = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (!free_found && state_q[i] == S_FREE) begin
        free_found = 1'b1;
        grant_tag  = TAG_W'(i);
      end
    end
`ifdef LOAD_TID_BUFFER_BYPASS_EN
    // The slot being freed by this cycle's response can be reused at once.
    if (!free_found && rsp_live) begin
      grant_tag = rsp_tag_i;
    end
`endif
  end

`ifdef LOAD_TID_BUFFER_BYPASS_EN
  assign alloc_ready_o = free_found || rsp_live;
`else
  assign alloc_ready_o = free_found;
`endif

  assign alloc_tag_o = grant_tag;
  assign handshake   = alloc_valid_i && alloc_ready_o;
  assign kill_en     = kill_last_i && last_vld_q;

  // Updates are applied in priority order: flush marking, then the response
  // free, then the kill free, and finally the allocation. Because the
  // allocation is applied last, it wins when a bypass reuses the same slot,
  // and the kill overrides the flush marking on the refused slot.
  always_comb begin
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      if (flush_i && state_q[i] == S_PENDING) begin
        state_d[i] = S_KILLED;
      end
    end
    if (rsp_live) begin
      state_d[rsp_tag_i] = S_FREE;
    end
    if (kill_en && state_q[last_tag_q] != S_FREE) begin
      state_d[last_tag_q] = S_FREE;
    end
    if (handshake) begin
      state_d[grant_tag] = flush_i ? S_KILLED : S_PENDING;
    end

    count_d = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (state_d[i] != S_FREE) begin
        count_d = count_d + CNT_W'(1);
      end
    end

    last_vld_d = handshake;
    last_tag_d = grant_tag;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= S_FREE;
      end
      last_vld_q <= 1'b0;
      last_tag_q <= '0;
      count_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
      end
      last_vld_q <= last_vld_d;
      last_tag_q <= last_tag_d;
      count_q    <= count_d;
    end
  end

  // The payload is written only on allocation and is never reset.
  always_ff @(posedge clk_i) begin
    if (handshake) begin
      tid_q[grant_tag] <= alloc_trans_id_i;
      off_q[grant_tag] <= alloc_offset_i;
      op_q[grant_tag]  <= alloc_op_i;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_load_tid_buffer.sv
// Testbench for load_tid_buffer. It runs directed scenarios with literal
// expectations and then a random phase. In both, a reference model that
// tracks slot occupancy checks every cycle.
module tb_load_tid_buffer;

  localparam int NR   = 2;
  localparam int TW   = 3;
  localparam int OW   = 3;
  localparam int PW   = 4;
  localparam int TAGW = 1;
  localparam int CW   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alloc_valid;
  logic            alloc_ready;
  logic [TW-1:0]   alloc_tid;
  logic [OW-1:0]   alloc_off;
  logic [PW-1:0]   alloc_op;
  logic [TAGW-1:0] alloc_tag;
  logic            kill_last;
  logic            flush;
  logic            rsp_valid;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_hit;
  logic            rsp_err;
  logic [TW-1:0]   rsp_tid;
  logic [OW-1:0]   rsp_off;
  logic [PW-1:0]   rsp_op;
  logic [CW-1:0]   count;
  logic            empty;

  always #5 clk = ~clk;

  load_tid_buffer #(
    .NR_ENTRIES(NR),
    .TRANS_ID_W(TW),
    .OFFSET_W  (OW),
    .OP_W      (PW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .alloc_valid_i   (alloc_valid),
    .alloc_ready_o   (alloc_ready),
    .alloc_trans_id_i(alloc_tid),
    .alloc_offset_i  (alloc_off),
    .alloc_op_i      (alloc_op),
    .alloc_tag_o     (alloc_tag),
    .kill_last_i     (kill_last),
    .flush_i         (flush),
    .rsp_valid_i     (rsp_valid),
    .rsp_tag_i       (rsp_tag),
    .rsp_hit_o       (rsp_hit),
    .rsp_err_o       (rsp_err),
    .rsp_trans_id_o  (rsp_tid),
    .rsp_offset_o    (rsp_off),
    .rsp_op_o        (rsp_op),
    .count_o         (count),
    .empty_o         (empty)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. occ: 0 = free, 1 = live load, 2 = in flight across a flush.
  int occ   [NR];
  int m_tid [NR];
  int m_off [NR];
  int m_op  [NR];
  bit m_last_ok;
  int m_last_tag;
  bit m_on = 1'b0;

  function automatic void m_grant(output bit rdy, output int tag);
    rdy = 1'b0;
    tag = 0;
    for (int i = 0; i < NR; i++) begin
      if (!rdy && occ[i] == 0) begin
        rdy = 1'b1;
        tag = i;
      end
    end
`ifdef LOAD_TID_BUFFER_BYPASS_EN
    if (!rdy && rsp_valid && occ[int'(rsp_tag)] != 0) begin
      rdy = 1'b1;
      tag = int'(rsp_tag);
    end
`endif
  endfunction

  // At each negedge the inputs hold the values for the coming posedge. The
  // process first checks the outputs against the model, then advances the
  // model by one edge.
  always @(negedge clk) begin
    bit rdy;
    int tag;
    int occupied;
    int rt;
    m_grant(rdy, tag);
    rt = int'(rsp_tag);
    if (m_on) begin
      occupied = 0;
      for (int i = 0; i < NR; i++) if (occ[i] != 0) occupied++;
      chk("ready", alloc_ready, rdy);
      if (alloc_valid && rdy) chk("alloc_tag", alloc_tag, tag);
      chk("rsp_hit", rsp_hit, rsp_valid && occ[rt] == 1);
      chk("rsp_err", rsp_err, rsp_valid && occ[rt] == 0);
      if (rsp_valid && occ[rt] != 0) begin
        chk("rsp_tid", rsp_tid, m_tid[rt]);
        chk("rsp_off", rsp_off, m_off[rt]);
        chk("rsp_op", rsp_op, m_op[rt]);
      end
      chk("count", count, occupied);
      chk("empty", empty, occupied == 0);
    end
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) occ[i] = 0;
      m_last_ok = 1'b0;
      m_last_tag = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      if (flush) for (int i = 0; i < NR; i++) if (occ[i] == 1) occ[i] = 2;
      if (rsp_valid) occ[rt] = 0;
      if (kill_last && m_last_ok) occ[m_last_tag] = 0;
      if (alloc_valid && rdy) begin
        occ[tag]   = flush ? 2 : 1;
        m_tid[tag] = int'(alloc_tid);
        m_off[tag] = int'(alloc_off);
        m_op[tag]  = int'(alloc_op);
      end
      m_last_ok  = alloc_valid && rdy;
      m_last_tag = tag;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0;
    kill_last   = 1'b0;
    flush       = 1'b0;
    rsp_valid   = 1'b0;
  endtask

  task automatic do_alloc(input int tid, input int off, input int op);
    idle();
    alloc_valid = 1'b1;
    alloc_tid = TW'(tid);
    alloc_off = OW'(off);
    alloc_op  = PW'(op);
  endtask

  task automatic do_rsp(input int tag);
    idle();
    rsp_valid = 1'b1;
    rsp_tag   = TAGW'(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    alloc_tid = '0;
    alloc_off = '0;
    alloc_op  = '0;
    rsp_tag   = '0;
    idle();
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("t1_ready", alloc_ready, 1);
    chk("t1_count", count, 0);
    chk("t1_empty", empty, 1);
    chk("t1_hit", rsp_hit, 0);
    tick();

    // Two allocations, then a response
    do_alloc(3, 2, 1);
    @(negedge clk); chk("t2_tag0", alloc_tag, 0);
    tick();
    do_alloc(5, 4, 2);
    @(negedge clk); chk("t2_tag1", alloc_tag, 1);
    tick();
    idle();
    @(negedge clk);
    chk("t2_count2", count, 2);
    chk("t2_ready0", alloc_ready, 0);
    tick();
    do_rsp(1);
    @(negedge clk);
    chk("t2_hit", rsp_hit, 1);
    chk("t2_tid", rsp_tid, 5);
    chk("t2_off", rsp_off, 4);
    tick();
    idle();
    @(negedge clk); chk("t2_count1", count, 1);
    tick();
    do_rsp(0);
    tick();
    idle();
    tick();

    // A flush holds in-flight slots until their responses arrive
    do_alloc(1, 1, 1); tick();
    do_alloc(2, 2, 2); tick();
    idle(); flush = 1'b1; tick();
    idle();
    @(negedge clk);
    chk("t3_count", count, 2);
    chk("t3_ready", alloc_ready, 0);
    tick();
    do_rsp(0);
    @(negedge clk);
    chk("t3_hit", rsp_hit, 0);
    chk("t3_err", rsp_err, 0);
    tick();
    do_rsp(1); tick();
    idle();
    @(negedge clk); chk("t3_empty", empty, 1);
    tick();

    // kill_last_i directly after a handshake, and kill_last_i with no handshake
    do_alloc(6, 0, 3);
    @(negedge clk); chk("t4_tag", alloc_tag, 0);
    tick();
    idle(); kill_last = 1'b1; tick();
    idle();
    @(negedge clk); chk("t4_count0", count, 0);
    tick();
    do_alloc(7, 7, 7); tick();
    idle(); tick();
    idle(); kill_last = 1'b1; tick();
    idle();
    @(negedge clk); chk("t4_nokill", count, 1);
    tick();
    do_rsp(0); tick();
    idle(); tick();

    // Full buffer, with an allocation and a response in the same cycle
    do_alloc(1, 1, 1); tick();
    do_alloc(2, 2, 2); tick();
    do_alloc(4, 3, 5);
    rsp_valid = 1'b1;
    rsp_tag = 1'b0;
    @(negedge clk);
`ifdef LOAD_TID_BUFFER_BYPASS_EN
    chk("t5_ready", alloc_ready, 1);
    chk("t5_tag", alloc_tag, 0);
`else
    chk("t5_ready", alloc_ready, 0);
`endif
    tick();
    idle();
    @(negedge clk);
`ifdef LOAD_TID_BUFFER_BYPASS_EN
    chk("t5_count", count, 2);
`else
    chk("t5_count", count, 1);
`endif
    tick();
    do_rsp(0); tick();
    do_rsp(1); tick();
    idle(); tick();

    // A response to a FREE slot
    do_rsp(1);
    @(negedge clk);
    chk("t6_err", rsp_err, 1);
    chk("t6_hit", rsp_hit, 0);
    tick();
    idle();
    @(negedge clk); chk("t6_count", count, 0);
    tick();

    // Random phase
    for (int n = 0; n < 3000; n++) begin
      rst_n       = ($urandom_range(0, 299) != 0);
      alloc_valid = ($urandom_range(0, 9) < 6);
      alloc_tid   = TW'($urandom);
      alloc_off   = OW'($urandom);
      alloc_op    = PW'($urandom);
      kill_last   = ($urandom_range(0, 9) < 2);
      flush       = ($urandom_range(0, 19) == 0);
      rsp_valid   = ($urandom_range(0, 9) < 4);
      rsp_tag     = TAGW'($urandom);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
